// File: rtl/regfile_arb_pkg.sv
// Shared widths, constants and types for the register-file read arbiter.
// Used by regfile_read_arbiter and its round-robin sub-module.
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    // X31 reads as zero when the zero-register option is built in.
    localparam reg_addr_t ZERO_REG = 5'd31;

    // Parked read-mux select while no requester is granted.
    localparam reg_addr_t IDLE_SEL = 5'd31;

endpackage

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// Round-robin arbiter: rotating-priority search starting at a pointer that
// advances past each winner. Grants are suppressed while i_enable is low.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_enable,
    input  logic [N-1:0]  i_valid,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] r_ptr;
    logic          w_found;
    logic [IW-1:0] w_idx;
    int            w_pos;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(r_ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (!w_found && i_valid[IW'(w_pos)]) begin
                w_found = 1'b1;
                w_idx   = IW'(w_pos);
            end
        end
    end

    assign o_idx   = w_idx;
    assign o_any   = w_found && i_enable;
    assign o_grant = o_any ? (N'(1) << w_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (o_any) begin
            r_ptr <= (w_idx == IW'(N-1)) ? '0 : w_idx + IW'(1);
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one register-file read port among NUM_REQ requesters with a
// one-cycle registered response. Option macro: REGFILE_ARB_ZERO_REG_EN.
module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [ADDR_W-1:0]   req_addr [NUM_REQ],
    output logic [NUM_REQ-1:0]  req_ready,
    output logic [ADDR_W-1:0]   rf_readRegister,
    input  logic [DATA_W-1:0]   rf_readData,
    output logic [NUM_REQ-1:0]  resp_valid,
    output logic [DATA_W-1:0]   resp_data,
    output logic [ADDR_W-1:0]   resp_addr
);

    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] w_grant;
    logic [IW-1:0]      w_idx;
    logic               w_any;
    logic               w_enable;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_rdata;

    logic [NUM_REQ-1:0] r_resp_valid;
    logic [DATA_W-1:0]  r_resp_data;
    logic [ADDR_W-1:0]  r_resp_addr;

    assign w_enable = !stall && !reset;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .clk      (clk),
        .reset    (reset),
        .i_enable (w_enable),
        .i_valid  (req_valid),
        .o_grant  (w_grant),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    assign w_sel_addr      = req_addr[w_idx];
    assign req_ready       = w_grant;
    assign rf_readRegister = w_any ? w_sel_addr : ADDR_W'(IDLE_SEL);

`ifdef REGFILE_ARB_ZERO_REG_EN
    assign w_rdata = (w_sel_addr == ADDR_W'(ZERO_REG)) ? '0 : rf_readData;
`else
    assign w_rdata = rf_readData;
`endif

    // Data/addr only load on a grant so they stay stable across idle and stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_resp_addr  <= '0;
        end else if (w_any) begin
            r_resp_valid <= w_grant;
            r_resp_data  <= w_rdata;
            r_resp_addr  <= w_sel_addr;
        end else begin
            r_resp_valid <= '0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_addr  = r_resp_addr;

    a_grant_onehot : assert property (@(posedge clk) $onehot0(req_ready));
    a_resp_onehot  : assert property (@(posedge clk) disable iff (reset) $onehot0(resp_valid));

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_regfile_read_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic [N-1:0]  req_valid;
    logic [4:0]    req_addr [N];
    logic [N-1:0]  req_ready;
    logic [4:0]    rf_readRegister;
    logic [63:0]   rf_readData;
    logic [N-1:0]  resp_valid;
    logic [63:0]   resp_data;
    logic [4:0]    resp_addr;

    logic [63:0]   mem [32];

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // model state
    int           m_ptr = 0;
    logic [N-1:0] m_rv = '0;
    logic [63:0]  m_rd = '0;
    logic [4:0]   m_ra = '0;
    int           m_g;

    always #5 clk = ~clk;

    assign rf_readData = mem[rf_readRegister];

    regfile_read_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (5),
        .DATA_W  (64)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_ready       (req_ready),
        .rf_readRegister (rf_readRegister),
        .rf_readData     (rf_readData),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_addr       (resp_addr)
    );

    function automatic int pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [63:0] read_value(logic [4:0] a);
`ifdef REGFILE_ARB_ZERO_REG_EN
        if (a == 5'd31) return 64'd0;
`endif
        return mem[a];
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model, updated on each rising edge from the sampled inputs
    always @(posedge clk) begin
        if (reset) begin
            m_ptr  = 0;
            m_rv   = '0;
            m_rd   = '0;
            m_ra   = '0;
            chk_en = 1'b1;
        end else begin
            m_g = pick(req_valid, m_ptr);
            if (!stall && m_g >= 0) begin
                m_rv  = N'(1) << m_g;
                m_ra  = req_addr[m_g];
                m_rd  = read_value(req_addr[m_g]);
                m_ptr = (m_g + 1) % N;
            end else begin
                m_rv = '0;
            end
        end
    end

    // continuous compare against the model, away from the active edge
    always @(negedge clk) begin
        int           g;
        logic [N-1:0] e_ready;
        logic [4:0]   e_sel;
        if (chk_en) begin
            g = pick(req_valid, m_ptr);
            if (!reset && !stall && g >= 0) begin
                e_ready = N'(1) << g;
                e_sel   = req_addr[g];
            end else begin
                e_ready = '0;
                e_sel   = 5'd31;
            end
            chk("model_req_ready", req_ready, e_ready);
            chk("model_rf_sel", rf_readRegister, e_sel);
            chk("model_resp_valid", resp_valid, m_rv);
            chk("model_resp_data", resp_data, m_rd);
            chk("model_resp_addr", resp_addr, m_ra);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] e1;
        logic [63:0]  zexp;

        reset     = 1'b1;
        stall     = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) req_addr[i] = 5'(i + 1);
        for (int i = 0; i < 32; i++) mem[i] = 64'h100 + 64'(i);

        // reset held two edges with everyone requesting
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_addr", resp_addr, 0);
        step();
        reset = 1'b0;

        // round robin 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            e1 = 4'b0001 << (k % 4);
            chk("rr_ready", req_ready, e1);
            chk("rr_sel", rf_readRegister, 5'(k % 4 + 1));
            if (k > 0) begin
                e1 = 4'b0001 << ((k - 1) % 4);
                chk("rr_resp_valid", resp_valid, e1);
                chk("rr_resp_data", resp_data, 64'h100 + 64'((k - 1) % 4 + 1));
            end
            step();
        end

        // grant to req 1, then stall three cycles
        @(negedge clk);
        chk("pre_stall_ready", req_ready, 4'b0010);
        step();
        stall = 1'b1;
        @(negedge clk);
        chk("stall_ready", req_ready, 0);
        chk("stall_resp_kept", resp_valid, 4'b0010);
        chk("stall_resp_data", resp_data, 64'h102);
        step();
        @(negedge clk);
        chk("stall_resp_clr", resp_valid, 0);
        chk("stall_data_hold", resp_data, 64'h102);
        chk("stall_addr_hold", resp_addr, 5'd2);
        step();
        step();
        stall = 1'b0;
        @(negedge clk);
        chk("post_stall_ready", req_ready, 4'b0100);
        step();

        // lone requester 2 on register 7
        req_valid   = 4'b0100;
        req_addr[2] = 5'd7;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("single_ready", req_ready, 4'b0100);
            if (k > 0) begin
                chk("single_resp_valid", resp_valid, 4'b0100);
                chk("single_resp_addr", resp_addr, 5'd7);
            end
            step();
        end

        // req 0 reads X31 while the mux returns a nonzero pattern
        req_valid   = 4'b0001;
        req_addr[0] = 5'd31;
        mem[31]     = 64'hDEADBEEF;
        @(negedge clk);
        chk("single_last_resp", resp_addr, 5'd7);
        chk("zero_ready", req_ready, 4'b0001);
        chk("zero_sel", rf_readRegister, 5'd31);
        step();
`ifdef REGFILE_ARB_ZERO_REG_EN
        zexp = 64'd0;
`else
        zexp = 64'hDEADBEEF;
`endif
        req_valid   = 4'b0010;
        req_addr[1] = 5'd5;
        @(negedge clk);
        chk("zero_resp_data", resp_data, zexp);
        chk("zero_resp_valid", resp_valid, 4'b0001);
        chk("midrst_pre_ready", req_ready, 4'b0010);
        step();

        // reset in the cycle after a grant
        reset       = 1'b1;
        req_valid   = 4'b1010;
        req_addr[3] = 5'd9;
        @(negedge clk);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_inflight", resp_valid, 4'b0010);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_resp_clr", resp_valid, 0);
        chk("midrst_regrant", req_ready, 4'b0010);
        step();

        // randomized traffic with occasional stall and reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_rv[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_addr[i]  = 5'($urandom_range(0, 31));
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            mem[$urandom_range(0, 31)] = {$urandom, $urandom};
            step();
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_read_arbiter.md
Name: regfile_read_arbiter

Overview:
- Shares one 64-bit register-file read port (32 x 64-bit entries, 5-bit select) between NUM_REQ requesters, e.g. decode port A, decode port B, store-data read and debug.
- Round-robin arbitration with a valid/ready handshake.
- Drives the read-mux select, captures the returned data, and delivers a registered, one-hot-tagged response one cycle later.
- Sits between the decode/issue stage and the register-file read mux.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- ADDR_W, 5, register address width.
- DATA_W, 64, register data width.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- stall, input, 1, freezes arbitration; no grants while high.
- req_valid, input, NUM_REQ, per-requester request.
- req_addr, input, [ADDR_W-1:0] x NUM_REQ (unpacked array), per-requester register number.
- req_ready, output, NUM_REQ, one-hot grant in the current cycle.
- rf_readRegister, output, ADDR_W, select to the register-file read mux.
- rf_readData, input, DATA_W, combinational data from the read mux.
- resp_valid, output, NUM_REQ, one-hot; response belongs to this requester.
- resp_data, output, DATA_W, registered read data.
- resp_addr, output, ADDR_W, register number of the response.

Behaviour:
- Reset: the following registers clear on the first clk edge with reset high. Reset overrides stall and all requests.
  - ptr = 0.
  - resp_valid = 0.
  - resp_data = 0.
  - resp_addr = 0.
- Grant logic (combinational, cycle t):
  - g = first index i with req_valid[i]=1, searching ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - req_ready = one-hot(g) if any valid and !stall and !reset; otherwise 0.
  - req_ready never depends on req_ready; it depends only on req_valid, ptr, stall and reset.
- Select: rf_readRegister = req_addr[g] when granted; otherwise 5'd31, a static idle value that avoids select toggling.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - Requesters hold req_valid and req_addr stable until granted.
  - Dropping valid before grant is legal and withdraws the request.
- Latency is exactly 1 cycle. At edge t+1:
  - resp_valid = one-hot(g).
  - resp_data = rf_readData sampled at t.
  - resp_addr = req_addr[g].
- Pointer: on a grant, ptr <= (g == NUM_REQ-1) ? 0 : g+1. With no grant, ptr holds.
- Idle cycle (no valid, not stalled): at the next edge resp_valid <= 0; resp_data and resp_addr hold.
- Stall:
  - req_ready = 0 and ptr holds.
  - resp_valid <= 0 at the next edge; resp_data and resp_addr hold.
  - A response already registered before stall rose stays visible for its one cycle, then clears.
- Throughput: one grant per cycle. A lone continuous requester is granted every cycle.
- Fairness: with all NUM_REQ valid, grants rotate 0,1,...,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 cycles.
- Reset mid-operation:
  - An in-flight response is discarded (resp_valid = 0 after the edge).
  - Requests still held are re-arbitrated from ptr=0 once reset deasserts.
- Writes to the register file are outside this block. Same-cycle write/read ordering is the register file's responsibility; the arbiter just samples rf_readData.

Optional Feature:
- Macro: REGFILE_ARB_ZERO_REG_EN.
- Defined: a granted request with req_addr == 31 (XZR) registers resp_data = 0 regardless of rf_readData. Arbitration and latency are unchanged.
- Undefined: resp_data always equals the sampled rf_readData.

Decomposition:
- Package regfile_arb_pkg holds:
  - REG_ADDR_W = 5.
  - REG_DATA_W = 64.
  - ZERO_REG = 5'd31.
  - IDLE_SEL = 5'd31.
  - typedef reg_addr_t logic [4:0].
  - typedef reg_data_t logic [63:0].
- Sub-module rr_arbiter (parameter N) contains:
  - the pointer register;
  - the rotate-priority search;
  - outputs: one-hot grant, binary index, any_grant.
- The top level adds the select mux, the response registers and the stall/reset gating.

Test Plan:
- Reset: hold reset 2 cycles with all req_valid=1 -> req_ready=0, resp_valid=0, resp_data=0; after release, first grant goes to requester 0.
- Round-robin: all 4 valid with addrs 1,2,3,4 and rf_readData = 0x100+select -> grants 0,1,2,3,0 on consecutive cycles; resp_data 0x101, 0x102, 0x103, 0x104 one cycle after each grant, with matching resp_valid one-hot.
- Single requester: only req 2 valid, addr 7, for 5 cycles -> req_ready[2]=1 every cycle; 5 responses, resp_addr=7.
- Stall: all valid, stall=1 for 3 cycles mid-sequence after grant to req 1 -> no grants, resp_valid clears after one cycle, ptr held; after stall drops, next grant is req 2.
- Zero reg: req 0 reads addr 31 with rf_readData=0xDEADBEEF -> resp_data=0 with REGFILE_ARB_ZERO_REG_EN defined, 0xDEADBEEF without it.
- Reset mid-flight: assert reset in the cycle after a grant -> resp_valid=0, ptr=0; the held request is re-granted after release.
